mux8lut_config_loader: RTL and testbench



---
 rtl/mux8lut_config_loader.sv | 128 ++++++++++++
 tb/tb_mux8lut_config_loader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mux8lut_config_loader.sv
// Stream-fed frame loader for a column of MUX8LUT BELs.
// Frames are assembled in a shadow register and committed atomically.
module mux8lut_config_loader #(
  parameter int NUM_BELS     = 8,
  parameter int BITS_PER_BEL = 2,
  parameter int WORD_W       = 8,
  parameter int NUM_WORDS    = 2
) (
  input  logic                             CLK,
  input  logic                             resetn,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WORD_W-1:0]                in_data,
  input  logic                             in_last,
  input  logic                             cfg_lock,
  input  logic                             err_clr,
  output logic [NUM_BELS*BITS_PER_BEL-1:0] ConfigBits,
  output logic                             commit_pulse,
  output logic                             busy,
  output logic                             err_sticky,
  output logic [7:0]                       frame_count
);

  localparam int CW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    HOLD,
    COMMIT,
    DRAIN
  } state_t;

  state_t                      state;
  logic [CW-1:0]               cnt;
  logic [NUM_WORDS*WORD_W-1:0] shadow;
  logic                        accept;

  assign accept = in_valid & in_ready;

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      cnt          <= '0;
      shadow       <= '0;
      ConfigBits   <= '0;
      commit_pulse <= 1'b0;
      err_sticky   <= 1'b0;
      frame_count  <= 8'd0;
      in_ready     <= 1'b1;
      busy         <= 1'b0;
    end else begin
      commit_pulse <= 1'b0;
      // a detected error later in this block overrides the clear
      if (err_clr)
        err_sticky <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            shadow[WORD_W-1:0] <= in_data;
            cnt                <= CW'(1);
            if (NUM_WORDS > 1) begin
              if (in_last) begin
                err_sticky <= 1'b1;
              end else begin
                state <= SHIFT;
                busy  <= 1'b1;
              end
            end else if (in_last) begin
              state    <= cfg_lock ? HOLD : COMMIT;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end else begin
              err_sticky <= 1'b1;
              state      <= DRAIN;
              busy       <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (accept) begin
            shadow[cnt*WORD_W +: WORD_W] <= in_data;
            cnt <= cnt + CW'(1);
            if (cnt != LAST_IDX) begin
              if (in_last) begin
                err_sticky <= 1'b1;
                state      <= IDLE;
                busy       <= 1'b0;
              end
            end else if (in_last) begin
              state    <= cfg_lock ? HOLD : COMMIT;
              in_ready <= 1'b0;
            end else begin
              err_sticky <= 1'b1;
              state      <= DRAIN;
            end
          end
        end
        HOLD: begin
          if (!cfg_lock)
            state <= COMMIT;
        end
        COMMIT: begin
          ConfigBits   <= shadow;
          commit_pulse <= 1'b1;
          frame_count  <= frame_count + 8'd1;
          cnt          <= '0;
          state        <= IDLE;
          in_ready     <= 1'b1;
          busy         <= 1'b0;
        end
        DRAIN: begin
          if (accept && in_last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux8lut_config_loader.sv
// Directed bench for mux8lut_config_loader: per-cycle vector table
// plus hand sequences for lock hold, count wrap and async reset.
module tb_mux8lut_config_loader;

  logic        CLK = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        cfg_lock;
  logic        err_clr;
  logic [15:0] ConfigBits;
  logic        commit_pulse;
  logic        busy;
  logic        err_sticky;
  logic [7:0]  frame_count;

  int n_pass = 0;
  int n_total = 0;

  mux8lut_config_loader dut (
    .CLK          (CLK),
    .resetn       (resetn),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .cfg_lock     (cfg_lock),
    .err_clr      (err_clr),
    .ConfigBits   (ConfigBits),
    .commit_pulse (commit_pulse),
    .busy         (busy),
    .err_sticky   (err_sticky),
    .frame_count  (frame_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        clr;
    logic [27:0] exp;
  } row_t;

  row_t tbl[17];

  function automatic row_t r(
    input logic v, input logic [7:0] d, input logic l, input logic clr,
    input logic rdy, input logic bsy, input logic pls, input logic err,
    input logic [7:0] fc, input logic [15:0] cfg);
    row_t x;
    x.v   = v;
    x.d   = d;
    x.l   = l;
    x.clr = clr;
    x.exp = {rdy, bsy, pls, err, fc, cfg};
    return x;
  endfunction

  function automatic logic [27:0] snap();
    return {in_ready, busy, commit_pulse, err_sticky, frame_count, ConfigBits};
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic word(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] w0, input logic [7:0] w1);
    word(w0, 1'b0);
    word(w1, 1'b1);
    tick();
  endtask

  int pulses;

  initial begin
    // ready,busy,pulse,err,fc,cfg after each edge
    tbl[0]  = r(1, 8'hA5, 0, 0, 1, 1, 0, 0, 0, 16'h0000);
    tbl[1]  = r(0, 8'h00, 0, 0, 1, 1, 0, 0, 0, 16'h0000);
    tbl[2]  = r(1, 8'h3C, 1, 0, 0, 1, 0, 0, 0, 16'h0000);
    tbl[3]  = r(0, 8'h00, 0, 0, 1, 0, 1, 0, 1, 16'h3CA5);
    tbl[4]  = r(0, 8'h00, 0, 0, 1, 0, 0, 0, 1, 16'h3CA5);
    tbl[5]  = r(1, 8'h11, 1, 0, 1, 0, 0, 1, 1, 16'h3CA5);
    tbl[6]  = r(1, 8'h01, 0, 0, 1, 1, 0, 1, 1, 16'h3CA5);
    tbl[7]  = r(1, 8'h80, 1, 0, 0, 1, 0, 1, 1, 16'h3CA5);
    tbl[8]  = r(0, 8'h00, 0, 0, 1, 0, 1, 1, 2, 16'h8001);
    tbl[9]  = r(0, 8'h00, 0, 1, 1, 0, 0, 0, 2, 16'h8001);
    tbl[10] = r(1, 8'h01, 0, 0, 1, 1, 0, 0, 2, 16'h8001);
    tbl[11] = r(1, 8'h02, 0, 0, 1, 1, 0, 1, 2, 16'h8001);
    tbl[12] = r(1, 8'h03, 0, 0, 1, 1, 0, 1, 2, 16'h8001);
    tbl[13] = r(1, 8'h04, 1, 0, 1, 0, 0, 1, 2, 16'h8001);
    tbl[14] = r(0, 8'h00, 0, 1, 1, 0, 0, 0, 2, 16'h8001);
    tbl[15] = r(1, 8'h11, 1, 1, 1, 0, 0, 1, 2, 16'h8001);
    tbl[16] = r(0, 8'h00, 0, 1, 1, 0, 0, 0, 2, 16'h8001);

    resetn   = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    cfg_lock = 1'b0;
    err_clr  = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
    chk("reset_state", 64'(snap()), 64'({4'b1000, 8'd0, 16'h0000}));

    foreach (tbl[i]) begin
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      in_last  = tbl[i].l;
      err_clr  = tbl[i].clr;
      tick();
      chk($sformatf("row%0d", i), 64'(snap()), 64'(tbl[i].exp));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    err_clr  = 1'b0;

    cfg_lock = 1'b1;
    word(8'hFF, 1'b0);
    word(8'hFF, 1'b1);
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_data  = 8'h00;
      tick();
      chk($sformatf("hold%0d", c), 64'({in_ready, busy, ConfigBits}),
          64'({2'b01, 16'h8001}));
    end
    in_valid = 1'b0;
    cfg_lock = 1'b0;
    tick();
    chk("unlock_commit_state", 64'({in_ready, busy, ConfigBits}),
        64'({2'b01, 16'h8001}));
    tick();
    chk("unlock_cfg", 64'(snap()), 64'({4'b1010, 8'd3, 16'hFFFF}));

    pulses = 0;
    for (int f = 0; f < 253; f++) begin
      send_frame(8'(f), ~8'(f));
      if (commit_pulse) pulses++;
    end
    chk("wrap_pulses", 64'(pulses), 64'(253));
    chk("wrap_count", 64'(frame_count), 64'(0));
    chk("wrap_cfg", 64'(ConfigBits), 64'h03FC);

    word(8'h55, 1'b0);
    #2 resetn = 1'b0;
    #1;
    chk("rst_mid_frame", 64'(snap()), 64'({4'b1000, 8'd0, 16'h0000}));
    tick();
    resetn = 1'b1;
    tick();
    send_frame(8'h12, 8'h34);
    chk("after_rst_frame", 64'(snap()), 64'({4'b1010, 8'd1, 16'h3412}));

    cfg_lock = 1'b1;
    word(8'hAA, 1'b0);
    word(8'hBB, 1'b1);
    chk("in_hold", 64'({in_ready, busy, ConfigBits}), 64'({2'b01, 16'h3412}));
    #2 resetn = 1'b0;
    #1;
    chk("rst_in_hold", 64'(snap()), 64'({4'b1000, 8'd0, 16'h0000}));
    tick();
    resetn   = 1'b1;
    cfg_lock = 1'b0;
    tick();
    send_frame(8'h12, 8'h34);
    chk("after_hold_rst", 64'(snap()), 64'({4'b1010, 8'd1, 16'h3412}));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
